rr_arb8: RTL and testbench
==========================

Name: rr_arb8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Produces a registered one-hot grant vector, plus the grant index in 3-bit binary, i.e. the one-hot-to-binary mapping of the priority-encoder datapath.
- Sits in front of the shared resource; each requester holds its request for as long as it needs the resource.
- A hold-time limit stops any single requester from starving the others.

Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles per requester; 0 = unlimited.
- CNT_W, 5: hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- REQ  input  [0:7]  request lines; REQ[0] = requester 0 (leftmost bit)
- GNT  output  [0:7]  registered one-hot grant; all zero when idle
- GIDX  output  [2:0]  binary index of the granted requester (requester i -> i; requester 0 -> 3'b000, requester 7 -> 3'b111)
- VALID  output  1  high while GNT is non-zero
- TIMEOUT  output  1  one-cycle pulse when a grant is forcibly revoked

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, PTR=3'd0, hold counter=0, GNT=8'b0, GIDX=3'b000, VALID=0, TIMEOUT=0.
- Reset mid-grant: GNT drops the cycle after rst is sampled, with no RELEASE cycle. PTR returns to 0.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If REQ==0, stay in IDLE.
  - Otherwise select the first asserted REQ[i], scanning i = PTR, PTR+1, ..., 7, 0, ..., PTR-1 (mod 8).
  - At the next edge: GNT[i]=1, GIDX=i, VALID=1, counter=1, state goes to GRANT.
  - Latency from REQ sampled in IDLE to GNT visible is 1 cycle.
- GRANT (granted index g):
  - If REQ[g]==0: go to RELEASE, no TIMEOUT.
  - Else if MAX_HOLD!=0 and counter==MAX_HOLD: go to RELEASE and assert TIMEOUT for exactly that RELEASE cycle.
  - Else counter+1, stay in GRANT.
  - Other requesters toggling during GRANT have no effect.
- RELEASE:
  - GNT=0, VALID=0, GIDX holds its last value.
  - PTR <= g+1 (mod 8; g=7 wraps to 0).
  - Next state is always IDLE.
  - Handover gap: requester drops at edge n; new grant visible at edge n+2. The bus is idle for 2 cycles, so no two grants are ever in adjacent cycles.
- Timeout case: if the timed-out requester is still asserting, it is eligible again only after every other active requester has had its turn (PTR has already moved past it).
- Single requester: it is re-granted after each release or timeout, with the same 2-cycle gap.
- Invariants: GNT is always one-hot or zero. VALID == |GNT. GIDX equals the encoded GNT whenever VALID=1.

Decomposition:
- Shared package (arb_pkg) holds:
  - state encoding constants: IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2
  - N_REQ=8
  - IDX_W=3
- Sub-module rr_pick8 is combinational:
  - Inputs: REQ[0:7] and PTR[2:0].
  - Outputs: one-hot pick[0:7], index[2:0], any.
  - Implementation: rotate REQ by PTR, fixed-priority select, then the one-hot-to-binary encode.
- All registers, the FSM and the hold counter live in rr_arb8.

Test Plan:
- Reset then REQ=8'b0010_0000 (requester 2) -> next cycle GNT=8'b0010_0000, GIDX=3'b010, VALID=1. Drop REQ -> RELEASE (GNT=0), then IDLE.
- REQ=8'b1111_1111 held, each requester drops after 3 grant cycles and re-raises immediately -> grant order 0,1,2,...,7,0, each 3 cycles long, separated by 2-cycle gaps.
- MAX_HOLD=4, requester 5 held continuously together with requester 1 -> requester 5 granted for 4 cycles, TIMEOUT pulses once, next grant goes to requester 1 (PTR=6 wraps), then back to 5.
- PTR=7 after requester 6 released, REQ=8'b0000_0001 | 8'b1000_0000 -> requester 7 wins, then requester 0 (wrap-around check).
- rst asserted during GRANT of requester 3 -> next cycle GNT=0, VALID=0, GIDX=0, TIMEOUT=0. Subsequent REQ=8'b0001_0001 -> requester 3 granted (PTR=0 scan order; requester 3 is the first asserted bit).
- Random REQ for 10k cycles with checker -> GNT always one-hot or zero, GIDX matches GNT, no requester waits more than 7 grants while asserting.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes and FSM encoding.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arb8_if;
    import arb_pkg::*;

    logic [0:N_REQ-1] REQ;
    logic [0:N_REQ-1] GNT;
    logic [IDX_W-1:0] GIDX;
    logic             VALID;
    logic             TIMEOUT;

    modport master (output REQ, input GNT, input GIDX, input VALID, input TIMEOUT);
    modport slave  (input REQ, output GNT, output GIDX, output VALID, output TIMEOUT);
endinterface

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first asserted request at or after ptr, with its binary index.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [0:N_REQ-1] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [0:N_REQ-1] pick,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    logic [0:N_REQ-1] rot;
    logic [0:N_REQ-1] rot_pick;
    logic             found;

    // rot[k] is requester (ptr + k) mod 8, so slot 0 has the highest priority.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [IDX_W-1:0] src;
            logic [IDX_W-1:0] dst;
            assign src       = ptr + IDX_W'(gi);
            assign dst       = IDX_W'(gi) - ptr;
            assign rot[gi]   = req[src];
            assign pick[gi]  = rot_pick[dst];
        end
    endgenerate

    always_comb begin
        rot_pick = '0;
        found    = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (rot[k] && !found) begin
                rot_pick[k] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    always_comb begin
        index = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) begin
                index = index | IDX_W'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_arb8.sv
// Round-robin arbiter for 8 requesters with registered grant and a per-grant hold limit.
module rr_arb8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    rr_arb8_if.slave   bus
);

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  ptr_reg, ptr_next;
    logic [IDX_W-1:0]  gidx_reg, gidx_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [0:N_REQ-1]  gnt_reg, gnt_next;
    logic              valid_reg, valid_next;
    logic              timeout_reg, timeout_next;

    logic [0:N_REQ-1]  pick;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              hold_expired;

    rr_pick8 u_pick (
        .req   (bus.REQ),
        .ptr   (ptr_reg),
        .pick  (pick),
        .index (pick_idx),
        .any   (pick_any)
    );

    assign hold_expired = (MAX_HOLD != 0) && (cnt_reg == CNT_W'(MAX_HOLD));

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        gidx_next    = gidx_reg;
        cnt_next     = cnt_reg;
        gnt_next     = gnt_reg;
        valid_next   = valid_reg;
        timeout_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    gnt_next   = pick;
                    gidx_next  = pick_idx;
                    valid_next = 1'b1;
                    cnt_next   = CNT_W'(1);
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (!bus.REQ[gidx_reg] || hold_expired) begin
                    gnt_next     = '0;
                    valid_next   = 1'b0;
                    timeout_next = bus.REQ[gidx_reg];
                    state_next   = RELEASE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            RELEASE: begin
                // Moving past the last winner is what makes a timed-out holder wait its turn.
                ptr_next   = gidx_reg + IDX_W'(1);
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: begin
                gnt_next   = '0;
                valid_next = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            gidx_reg    <= '0;
            cnt_reg     <= '0;
            gnt_reg     <= '0;
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            gidx_reg    <= gidx_next;
            cnt_reg     <= cnt_next;
            gnt_reg     <= gnt_next;
            valid_reg   <= valid_next;
            timeout_reg <= timeout_next;
        end
    end

    assign bus.GNT     = gnt_reg;
    assign bus.GIDX    = gidx_reg;
    assign bus.VALID   = valid_reg;
    assign bus.TIMEOUT = timeout_reg;

endmodule

// File: tb/tb_rr_arb8.sv
// Directed and random checks of rr_arb8 built with a hold limit of 4 cycles.
module tb_rr_arb8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    rr_arb8_if bus ();

    rr_arb8 #(.MAX_HOLD(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:7] oh(input int g);
        logic [0:7] v;
        v    = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    task automatic expect_out(input string tag, input logic [0:7] gnt, input logic [2:0] gidx,
                              input logic valid, input logic to);
        $display("[%0t] %s req=%b gnt=%b gidx=%0d valid=%0b timeout=%0b", $time, tag,
                 bus.REQ, bus.GNT, bus.GIDX, bus.VALID, bus.TIMEOUT);
        check_eq({tag, ".gnt"},     32'(bus.GNT),     32'(gnt));
        check_eq({tag, ".gidx"},    32'(bus.GIDX),    32'(gidx));
        check_eq({tag, ".valid"},   32'(bus.VALID),   32'(valid));
        check_eq({tag, ".timeout"}, 32'(bus.TIMEOUT), 32'(to));
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.REQ = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Random-phase monitor state
    logic       mon_en;
    logic       valid_prev;
    logic [0:7] req_prev;
    int         wait_cnt [8];

    always @(negedge clk) begin
        if (mon_en) begin
            logic [2:0] enc;
            enc = '0;
            for (int i = 0; i < 8; i++) if (bus.GNT[i]) enc = 3'(i);
            check_eq("rnd.onehot0", 32'($onehot0(bus.GNT)), 32'd1);
            check_eq("rnd.valid", 32'(bus.VALID), 32'(|bus.GNT));
            if (bus.VALID) check_eq("rnd.gidx", 32'(bus.GIDX), 32'(enc));
            // A new grant was decided on the REQ seen at the previous falling edge.
            if (bus.VALID && !valid_prev) begin
                for (int i = 0; i < 8; i++) begin
                    if (i == int'(enc)) wait_cnt[i] = 0;
                    else if (req_prev[i]) begin
                        wait_cnt[i]++;
                        check_eq("rnd.fair", 32'(wait_cnt[i] <= 7), 32'd1);
                    end else wait_cnt[i] = 0;
                end
            end
            valid_prev = bus.VALID;
            req_prev   = bus.REQ;
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        rst      = 1'b1;
        bus.REQ  = '0;

        // Reset state
        tick();
        tick();
        expect_out("reset", 8'b0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Single requester 2
        bus.REQ = 8'b0010_0000;
        tick(); expect_out("r2.grant", oh(2), 3'd2, 1'b1, 1'b0);
        bus.REQ = '0;
        tick(); expect_out("r2.release", 8'b0, 3'd2, 1'b0, 1'b0);
        tick(); expect_out("r2.idle", 8'b0, 3'd2, 1'b0, 1'b0);

        // Hold limit: PTR=3, requesters 1 and 5 held
        bus.REQ = 8'b0100_0100;
        tick(); expect_out("to.g5", oh(5), 3'd5, 1'b1, 1'b0);
        repeat (3) begin tick(); expect_out("to.hold5", oh(5), 3'd5, 1'b1, 1'b0); end
        tick(); expect_out("to.rel5", 8'b0, 3'd5, 1'b0, 1'b1);
        tick(); expect_out("to.idle5", 8'b0, 3'd5, 1'b0, 1'b0);
        tick(); expect_out("to.g1", oh(1), 3'd1, 1'b1, 1'b0);
        repeat (3) begin tick(); expect_out("to.hold1", oh(1), 3'd1, 1'b1, 1'b0); end
        tick(); expect_out("to.rel1", 8'b0, 3'd1, 1'b0, 1'b1);
        tick(); expect_out("to.idle1", 8'b0, 3'd1, 1'b0, 1'b0);
        tick(); expect_out("to.g5b", oh(5), 3'd5, 1'b1, 1'b0);
        bus.REQ = '0;
        tick(); expect_out("to.rel5b", 8'b0, 3'd5, 1'b0, 1'b0);
        tick();

        // All requesters, 3-cycle holds, immediate re-raise
        do_reset();
        bus.REQ = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            int g;
            g = k % 8;
            tick(); expect_out("rr.grant", oh(g), 3'(g), 1'b1, 1'b0);
            repeat (2) begin tick(); expect_out("rr.hold", oh(g), 3'(g), 1'b1, 1'b0); end
            bus.REQ[g] = 1'b0;
            tick(); expect_out("rr.release", 8'b0, 3'(g), 1'b0, 1'b0);
            bus.REQ[g] = 1'b1;
            tick(); expect_out("rr.idle", 8'b0, 3'(g), 1'b0, 1'b0);
        end
        bus.REQ = '0;
        tick();
        tick();
        tick();

        // Pointer wrap: 6 released -> PTR=7, then 7 and 0 both request
        do_reset();
        bus.REQ = oh(6);
        tick(); expect_out("wrap.g6", oh(6), 3'd6, 1'b1, 1'b0);
        bus.REQ = '0;
        tick(); expect_out("wrap.rel6", 8'b0, 3'd6, 1'b0, 1'b0);
        bus.REQ = 8'b1000_0001;
        tick();
        tick(); expect_out("wrap.g7", oh(7), 3'd7, 1'b1, 1'b0);
        bus.REQ = oh(0);
        tick(); expect_out("wrap.rel7", 8'b0, 3'd7, 1'b0, 1'b0);
        tick();
        tick(); expect_out("wrap.g0", oh(0), 3'd0, 1'b1, 1'b0);
        bus.REQ = '0;
        tick();
        tick();

        // Reset in the middle of a grant
        do_reset();
        bus.REQ = oh(3);
        tick(); expect_out("rst.g3", oh(3), 3'd3, 1'b1, 1'b0);
        tick(); expect_out("rst.hold3", oh(3), 3'd3, 1'b1, 1'b0);
        rst = 1'b1;
        tick(); expect_out("rst.cleared", 8'b0, 3'd0, 1'b0, 1'b0);
        rst     = 1'b0;
        bus.REQ = 8'b0001_0001;
        tick(); expect_out("rst.g3b", oh(3), 3'd3, 1'b1, 1'b0);
        bus.REQ = '0;
        tick();
        tick();

        // Random requests with invariant and fairness monitor
        do_reset();
        valid_prev = 1'b0;
        req_prev   = '0;
        for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
        mon_en = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            tick();
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(7) == 0) bus.REQ[i] = ~bus.REQ[i];
            end
        end
        tick();
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
